// File: rtl/sram_read_slave.sv
// sram_read_slave: AXI4 read-channel slave that serves bursts from a
// single-port synchronous SRAM (one-cycle read latency).
// Optional build macro: SRAM_RD_RESP_CHECK_EN. When it is defined, requests
// with an unsupported size or the reserved burst type get SLVERR with zero
// data, and the SRAM is never touched for them.
module sram_read_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ARID_S,
  input  logic [31:0] ARADDR_S,
  input  logic [3:0]  ARLEN_S,
  input  logic [2:0]  ARSIZE_S,
  input  logic [1:0]  ARBURST_S,
  input  logic        ARVALID_S,
  output logic        ARREADY_S,
  output logic [7:0]  RID_S,
  output logic [31:0] RDATA_S,
  output logic [1:0]  RRESP_S,
  output logic        RLAST_S,
  output logic        RVALID_S,
  input  logic        RREADY_S,
  output logic        CEB,
  output logic        WEB,
  output logic [13:0] A,
  input  logic [31:0] DO
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_id;
  logic [3:0]  r_len;
  logic [3:0]  r_beat;
  logic [1:0]  r_burst;
  logic [13:0] r_addr;
  logic [13:0] r_a_last;
  logic [31:0] r_hold;
  logic        r_fresh;
  logic        r_err;

  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_last;
  logic        w_ar_err;
  logic        w_issue;
  logic [13:0] w_next_addr;
  logic [13:0] w_issue_addr;

  assign ARREADY_S = (r_state == IDLE) && !rst;
  assign RVALID_S  = (r_state == DATA);

  assign w_ar_hs = ARVALID_S && ARREADY_S;
  assign w_r_hs  = RVALID_S && RREADY_S;
  assign w_last  = (r_beat == r_len);

  // FIXED bursts re-read the same word; INCR and WRAP both step by one word
  // and the 14-bit counter rolls over naturally at the top of the SRAM.
  assign w_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + 14'd1;

`ifdef SRAM_RD_RESP_CHECK_EN
  logic w_unused_bits;
  assign w_ar_err      = (ARSIZE_S != 3'b010) || (ARBURST_S == 2'b11);
  assign w_unused_bits = ^{ARADDR_S[31:16], ARADDR_S[1:0]};
`else
  logic w_unused_bits;
  assign w_ar_err      = 1'b0;
  assign w_unused_bits = ^{ARSIZE_S, ARADDR_S[31:16], ARADDR_S[1:0]};
`endif

  // NOTE: the SRAM strobe is combinational on purpose: a read must be issued
  // in the same cycle as the AR or R handshake so the data lands exactly one
  // cycle later, which is what gives back-to-back beats with no bubbles.
  assign w_issue = !rst && ((w_ar_hs && !w_ar_err) ||
                            (w_r_hs && !w_last && !r_err));
  assign w_issue_addr = w_ar_hs ? ARADDR_S[15:2] : w_next_addr;

  assign CEB = !w_issue;
  assign WEB = 1'b1;
  assign A   = w_issue ? w_issue_addr : r_a_last;

  // R channel: fresh SRAM data goes straight out, a stalled beat is replayed
  // from the hold register so the payload stays stable under backpressure.
  assign RID_S   = r_id;
  assign RRESP_S = (RVALID_S && r_err) ? 2'b10 : 2'b00;
  assign RLAST_S = RVALID_S && w_last;
  assign RDATA_S = r_err ? 32'h0 : (r_fresh ? DO : r_hold);

  // Burst sequencing, SRAM bookkeeping and the beat hold register.
  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_id     <= 8'h0;
      r_len    <= 4'h0;
      r_beat   <= 4'h0;
      r_burst  <= 2'b00;
      r_addr   <= 14'h0;
      r_a_last <= 14'h0;
      r_hold   <= 32'h0;
      r_fresh  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fresh <= w_issue;
      if (w_issue) begin
        r_a_last <= w_issue_addr;
      end
      if (r_fresh && !w_r_hs) begin
        r_hold <= DO;
      end
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_id    <= ARID_S;
            r_len   <= ARLEN_S;
            r_burst <= ARBURST_S;
            r_addr  <= ARADDR_S[15:2];
            r_beat  <= 4'h0;
            r_err   <= w_ar_err;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_r_hs) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_beat <= r_beat + 4'd1;
              r_addr <= w_next_addr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_read_slave.sv
// Bench for sram_read_slave: a transaction-level model predicts every R beat
// and the SRAM address sequence of each burst; a single compare process
// checks the DUT every cycle, and directed bursts add literal expectations.
module tb_sram_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        CEB;
  logic        WEB;
  logic [13:0] A;
  logic [31:0] DO;

  sram_read_slave dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
    .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CEB(CEB), .WEB(WEB), .A(A), .DO(DO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM contents: each word encodes its own address, so a wrong address
  // shows up as wrong data.
  function automatic logic [31:0] mem_val(input logic [13:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  // SRAM model: synchronous read, data one cycle after a CEB-low cycle.
  always @(posedge clk) begin
    if (!CEB) DO <= mem_val(A);
  end

  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [13:0] exp_a[$];
  logic [31:0] got_q[$];
  logic [13:0] a_log[$];
  int          ceb_lows = 0;
  logic [13:0] last_a = 14'h0;
  bit          mon_en = 1'b0;

  // Compare process: DUT vs model on every falling edge while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_a = 14'h0;
      end else if (mon_en) begin
        check("arready", ARREADY_S, exp_q.size() == 0);
        check("rvalid", RVALID_S, exp_q.size() != 0);
        check("web", WEB, 1'b1);
        if (RVALID_S && exp_q.size() != 0) begin
          check("rdata", RDATA_S, exp_q[0].data);
          check("rid",   RID_S,   exp_q[0].id);
          check("rresp", RRESP_S, exp_q[0].resp);
          check("rlast", RLAST_S, exp_q[0].last);
          if (RREADY_S) begin
            got_q.push_back(RDATA_S);
            void'(exp_q.pop_front());
          end
        end
        if (!CEB) begin
          ceb_lows++;
          a_log.push_back(A);
          last_a = A;
        end else begin
          check("a_hold", A, last_a);
        end
      end
    end
  end

  function automatic bit is_illegal(input logic [2:0] size, input logic [1:0] burst);
    bit r;
    r = 1'b0;
`ifdef SRAM_RD_RESP_CHECK_EN
    r = (size != 3'b010) || (burst == 2'b11);
`endif
    return r;
  endfunction

  // Model of one burst: the beats the R channel must return and the word
  // addresses the SRAM must see.
  task automatic push_model(input logic [7:0] id, input logic [13:0] base,
                            input logic [3:0] len, input logic [1:0] burst,
                            input bit illegal);
    logic [13:0] ak;
    beat_t b;
    exp_a.delete();
    for (int k = 0; k <= int'(len); k++) begin
      ak     = (burst == 2'b00) ? base : base + 14'(k);
      b.data = illegal ? 32'h0 : mem_val(ak);
      b.id   = id;
      b.resp = illegal ? 2'b10 : 2'b00;
      b.last = (k == int'(len));
      exp_q.push_back(b);
      if (!illegal) exp_a.push_back(ak);
    end
  endtask

  // Drive one burst from IDLE; called and returns at posedge+1.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input int stall_beat,
                           input int stall_n, input bit ar_hold, input string tag);
    bit illegal;
    int stall_left;
    int cyc;
    illegal    = is_illegal(size, burst);
    stall_left = stall_n;
    ceb_lows   = 0;
    a_log.delete();
    got_q.delete();
    ARID_S    = id;
    ARADDR_S  = addr;
    ARLEN_S   = len;
    ARBURST_S = burst;
    ARSIZE_S  = size;
    ARVALID_S = 1'b1;
    RREADY_S  = 1'b1;
    @(negedge clk);
    check({tag, "_ar_ceb"}, CEB, illegal);
    if (!illegal) check({tag, "_ar_a"}, A, addr[15:2]);
    @(posedge clk); #1;
    if (!ar_hold) ARVALID_S = 1'b0;
    push_model(id, addr[15:2], len, burst, illegal);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      RREADY_S = !(got_q.size() == stall_beat && stall_left > 0);
      if (!RREADY_S) stall_left--;
      @(posedge clk); #1;
      cyc++;
    end
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b1;
    check({tag, "_timeout"}, cyc < 100, 1'b1);
    check({tag, "_beats"}, got_q.size(), int'(len) + 1);
    check({tag, "_ceb_count"}, ceb_lows, illegal ? 0 : int'(len) + 1);
    check({tag, "_a_count"}, a_log.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < a_log.size(); i++)
      check($sformatf("%s_a%0d", tag, i), a_log[i], exp_a[i]);
  endtask

  function automatic logic [31:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; DO = 32'h0;
    ARID_S = 8'h0; ARADDR_S = 32'h0; ARLEN_S = 4'h0; ARSIZE_S = 3'b010;
    ARBURST_S = 2'b01; ARVALID_S = 1'b0; RREADY_S = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", ARREADY_S, 1'b0);
    check("rst_rvalid",  RVALID_S,  1'b0);
    check("rst_rlast",   RLAST_S,   1'b0);
    check("rst_rid",     RID_S,     8'h0);
    check("rst_rdata",   RDATA_S,   32'h0);
    check("rst_rresp",   RRESP_S,   2'b00);
    check("rst_ceb",     CEB,       1'b1);
    check("rst_web",     WEB,       1'b1);
    check("rst_a",       A,         14'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_burst(8'h85, 32'h0000_0010, 4'd0, 2'b01, 3'b010, -1, 0, 1'b0, "single");
    check("single_lit0", got(0), 32'h8004_4004);

    run_burst(8'h12, 32'h0000_0100, 4'd3, 2'b01, 3'b010, -1, 0, 1'b0, "incr4");
    check("incr4_lit0", got(0), 32'h8040_4040);
    check("incr4_lit3", got(3), 32'h8043_4043);

    run_burst(8'h93, 32'h0000_0100, 4'd3, 2'b01, 3'b010, 1, 3, 1'b1, "stall");
    check("stall_lit1", got(1), 32'h8041_4041);

    run_burst(8'h07, 32'h0000_FFFC, 4'd1, 2'b01, 3'b010, -1, 0, 1'b0, "wrap14");
    check("wrap14_lit0", got(0), 32'hBFFF_7FFF);
    check("wrap14_lit1", got(1), 32'h8000_4000);

    run_burst(8'h44, 32'h0000_0020, 4'd2, 2'b00, 3'b010, 2, 1, 1'b0, "fixed");
    check("fixed_lit2", got(2), 32'h8008_4008);

    run_burst(8'hC1, 32'h0000_0040, 4'd1, 2'b10, 3'b010, 0, 2, 1'b0, "wrapburst");

`ifdef SRAM_RD_RESP_CHECK_EN
    run_burst(8'h55, 32'h0000_0100, 4'd1, 2'b01, 3'b001, -1, 0, 1'b0, "illegal");
    check("illegal_lit0", got(0), 32'h0);
    run_burst(8'h56, 32'h0000_0100, 4'd0, 2'b01, 3'b010, -1, 0, 1'b0, "legal_after");
`endif

    // Reset in the middle of an 8-beat burst.
    ARID_S = 8'h3C; ARADDR_S = 32'h0000_0200; ARLEN_S = 4'd7;
    ARBURST_S = 2'b01; ARSIZE_S = 3'b010; ARVALID_S = 1'b1; RREADY_S = 1'b1;
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
    push_model(8'h3C, 14'h0080, 4'd7, 2'b01, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_rvalid",  RVALID_S,  1'b0);
    check("midrst_arready", ARREADY_S, 1'b0);
    check("midrst_ceb",     CEB,       1'b1);
    check("midrst_rlast",   RLAST_S,   1'b0);
    check("midrst_a",       A,         14'h0);
    rst = 1'b0;
    #1;
    check("midrst_arready_after", ARREADY_S, 1'b1);
    @(posedge clk); #1;
    run_burst(8'h21, 32'h0000_0300, 4'd1, 2'b01, 3'b010, -1, 0, 1'b0, "recover");
    check("recover_lit0", got(0), 32'h80C0_40C0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
